// File: rtl/osd_cmd_sequencer.sv
// OSD overlay command sequencer: frames io_osd, paces io_strobe, serialises words.
// Optional auto-hide after idle time: define OSD_SEQ_AUTOHIDE_EN.
module osd_cmd_sequencer #(
    parameter int          STROBE_GAP   = 2,
    parameter int          END_GAP      = 2,
    parameter logic [23:0] HIDE_TIMEOUT = 24'd10_000_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_line,
    input  logic [12:0] cmd_len,
    input  logic [11:0] info_x,
    input  logic [11:0] info_y,
    input  logic [5:0]  info_w,
    input  logic [5:0]  info_h,
    input  logic [1:0]  info_rot,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, SETUP, STRB_HI, STRB_LO, DATA_WAIT, TAIL} state_t;

    localparam logic [3:0] SGAP = 4'(STROBE_GAP - 1);
    localparam logic [3:0] EGAP = 4'(END_GAP - 1);

    state_t      state;
    logic [1:0]  op;
    logic [4:0]  line;
    logic [11:0] x, y;
    logic [5:0]  w, h;
    logic [1:0]  rot;
    logic [12:0] bytes_left;
    logic [2:0]  word_idx;
    logic [3:0]  gap_cnt;
    logic        hide_fire, hide_soon, accept;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready && !hide_fire;

    function automatic logic [15:0] word_at(input logic [2:0] i);
        logic [15:0] v;
        v = 16'h0040;
        case (op)
            2'd0: v = 16'h0040;
            2'd1: v = 16'h0041;
            2'd2: begin
                case (i)
                    3'd0:    v = 16'h0045;
                    3'd1:    v = {4'h0, x};
                    3'd2:    v = {4'h0, y};
                    3'd3:    v = {10'h0, w};
                    3'd4:    v = {10'h0, h};
                    default: v = {14'h0, rot};
                endcase
            end
            default: v = {10'h0, 1'b1, line};
        endcase
        return v;
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            wr_ready   <= 1'b0;
            io_osd     <= 1'b0;
            io_strobe  <= 1'b0;
            io_din     <= 16'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            op         <= 2'd0;
            line       <= 5'd0;
            x          <= 12'd0;
            y          <= 12'd0;
            w          <= 6'd0;
            h          <= 6'd0;
            rot        <= 2'd0;
            bytes_left <= 13'd0;
            word_idx   <= 3'd0;
            gap_cnt    <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hide_fire || accept) begin
                        state     <= SETUP;
                        io_osd    <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (hide_fire) begin
                            op <= 2'd0;
                        end else begin
                            op         <= cmd_op;
                            line       <= cmd_line;
                            bytes_left <= cmd_len;
                            x          <= info_x;
                            y          <= info_y;
                            w          <= info_w;
                            h          <= info_h;
                            rot        <= info_rot;
                        end
                    end else begin
                        cmd_ready <= !hide_soon;
                    end
                end
                SETUP: begin
                    state     <= STRB_HI;
                    io_strobe <= 1'b1;
                    io_din    <= word_at(3'd0);
                    word_idx  <= 3'd0;
                end
                STRB_HI: begin
                    state     <= STRB_LO;
                    io_strobe <= 1'b0;
                    gap_cnt   <= SGAP;
                end
                STRB_LO: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (op == 2'd2 && word_idx != 3'd5) begin
                        state     <= STRB_HI;
                        io_strobe <= 1'b1;
                        io_din    <= word_at(word_idx + 3'd1);
                        word_idx  <= word_idx + 3'd1;
                    end else if (op == 2'd3 && bytes_left != 13'd0) begin
                        state    <= DATA_WAIT;
                        wr_ready <= 1'b1;
                    end else begin
                        state   <= TAIL;
                        io_osd  <= 1'b0;
                        done    <= 1'b1;
                        gap_cnt <= EGAP;
                    end
                end
                DATA_WAIT: begin
                    if (wr_valid) begin
                        state      <= STRB_HI;
                        wr_ready   <= 1'b0;
                        io_strobe  <= 1'b1;
                        io_din     <= {8'h00, wr_data};
                        bytes_left <= bytes_left - 13'd1;
                    end
                end
                TAIL: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OSD_SEQ_AUTOHIDE_EN
    logic        armed;
    logic [23:0] idle_cnt;

    // cmd_ready drops one cycle early so a host never sees it high while auto-hide fires
    assign hide_fire = (state == IDLE) && armed && (idle_cnt == HIDE_TIMEOUT);
    assign hide_soon = (state == IDLE) && armed && (idle_cnt == HIDE_TIMEOUT - 24'd1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            armed    <= 1'b0;
            idle_cnt <= 24'd0;
        end else begin
            if (done) begin
                if (op == 2'd0)
                    armed <= 1'b0;
                else if (op != 2'd3)
                    armed <= 1'b1;
            end
            if (accept || hide_fire)
                idle_cnt <= 24'd0;
            else if (state == IDLE && armed && idle_cnt != HIDE_TIMEOUT)
                idle_cnt <= idle_cnt + 24'd1;
        end
    end
`else
    logic [23:0] unused_timeout;
    assign unused_timeout = HIDE_TIMEOUT;
    assign hide_fire = 1'b0;
    assign hide_soon = 1'b0;
`endif

endmodule

// File: tb/tb_osd_cmd_sequencer.sv
// Directed bench for osd_cmd_sequencer: strobe timing, word lists, stalls, reset.
module tb_osd_cmd_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_line = 5'd0;
    logic [12:0] cmd_len = 13'd0;
    logic [11:0] info_x = 12'd0;
    logic [11:0] info_y = 12'd0;
    logic [5:0]  info_w = 6'd0;
    logic [5:0]  info_h = 6'd0;
    logic [1:0]  info_rot = 2'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc, t_done, osd_drop, wr_hi;
    logic [15:0] strb_q[$];
    int          strb_t[$];

    osd_cmd_sequencer #(
        .STROBE_GAP(2),
        .END_GAP(2),
        .HIDE_TIMEOUT(24'd100)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_line(cmd_line), .cmd_len(cmd_len),
        .info_x(info_x), .info_y(info_y), .info_w(info_w),
        .info_h(info_h), .info_rot(info_rot),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din),
        .busy(busy), .done(done)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (io_strobe) begin
            strb_q.push_back(io_din);
            strb_t.push_back(cyc);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] ln, input logic [12:0] len);
        int n;
        cmd_op = op;
        cmd_line = ln;
        cmd_len = len;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        t_acc = cyc;
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_line = 5'd0;
        cmd_len = 13'd0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        t_done = -1;
        osd_drop = 0;
        wr_hi = 0;
        while (!seen && n < lim) begin
            @(negedge clk_sys);
            if (done) begin
                seen = 1'b1;
                t_done = cyc;
            end else if (!io_osd) begin
                osd_drop++;
            end
            if (wr_ready) wr_hi++;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done never seen within %0d cycles", lim);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({cmd_ready, wr_ready, io_osd, io_strobe, busy, done, io_din} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {cmd_ready, wr_ready, io_osd, io_strobe, busy, done, io_din});
        end
        reset = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_op1;
        logic [3:0] exp_v[8];
        exp_v = '{4'b0000, 4'b1000, 4'b1100, 4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0001};
        issue(2'd1, 5'd0, 13'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_sys);
            checks++;
            if ({io_osd, io_strobe, done, cmd_ready} !== exp_v[k]) begin
                errors++;
                $display("FAIL op1_T%0d: osd/strobe/done/ready=%b required %b",
                         k, {io_osd, io_strobe, done, cmd_ready}, exp_v[k]);
            end
            if (k == 2) begin
                checks++;
                if (io_din !== 16'h0041) begin
                    errors++;
                    $display("FAIL op1_din: got %h required 0041", io_din);
                end
            end
        end
    endtask

    task automatic test_info;
        logic [15:0] exp_w[6];
        exp_w = '{16'h0045, 16'h0123, 16'h0045, 16'h0006, 16'h0003, 16'h0001};
        strb_q.delete();
        strb_t.delete();
        info_x = 12'h123;
        info_y = 12'h045;
        info_w = 6'd6;
        info_h = 6'd3;
        info_rot = 2'd1;
        issue(2'd2, 5'd0, 13'd0);
        info_x = 12'hFFF;
        info_y = 12'hFFF;
        wait_done(100);
        checks++;
        if (strb_q.size() != 6) begin
            errors++;
            $display("FAIL info_count: got %0d strobes required 6", strb_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (strb_q[i] !== exp_w[i] || strb_t[i] != t_acc + 2 + 3 * i) begin
                    errors++;
                    $display("FAIL info_word%0d: got %h at +%0d required %h at +%0d",
                             i, strb_q[i], strb_t[i] - t_acc, exp_w[i], 2 + 3 * i);
                end
            end
        end
        checks++;
        if (t_done != t_acc + 2 + 18) begin
            errors++;
            $display("FAIL info_done: at +%0d required +20", t_done - t_acc);
        end
    endtask

    task automatic feed3;
        logic [7:0] b[3];
        int n;
        b = '{8'hA5, 8'h5A, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!wr_ready && n < 200) begin
                @(negedge clk_sys);
                n++;
            end
            if (i == 1) repeat (4) @(negedge clk_sys);
            wr_data = b[i];
            wr_valid = 1'b1;
            @(posedge clk_sys);
            #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic test_write;
        logic [15:0] exp_w[4];
        int exp_t[4];
        exp_w = '{16'h0029, 16'h00A5, 16'h005A, 16'h00FF};
        exp_t = '{2, 6, 14, 18};
        strb_q.delete();
        strb_t.delete();
        fork
            begin
                issue(2'd3, 5'd9, 13'd3);
                wait_done(200);
            end
            feed3();
        join
        checks++;
        if (strb_q.size() != 4) begin
            errors++;
            $display("FAIL write_count: got %0d strobes required 4", strb_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (strb_q[i] !== exp_w[i] || strb_t[i] != t_acc + exp_t[i]) begin
                    errors++;
                    $display("FAIL write_word%0d: got %h at +%0d required %h at +%0d",
                             i, strb_q[i], strb_t[i] - t_acc, exp_w[i], exp_t[i]);
                end
            end
        end
        checks++;
        if (t_done != t_acc + 21 || osd_drop != 0 || wr_hi != 7) begin
            errors++;
            $display("FAIL write_frame: done +%0d drops %0d wr_ready %0d required +21/0/7",
                     t_done - t_acc, osd_drop, wr_hi);
        end
    endtask

    task automatic test_len0;
        strb_q.delete();
        strb_t.delete();
        issue(2'd3, 5'd5, 13'd0);
        wait_done(100);
        checks++;
        if (strb_q.size() != 1 || t_done != t_acc + 5 || wr_hi != 0) begin
            errors++;
            $display("FAIL len0_frame: strobes %0d done +%0d wr_ready %0d required 1/+5/0",
                     strb_q.size(), t_done - t_acc, wr_hi);
        end else begin
            checks++;
            if (strb_q[0] !== 16'h0025) begin
                errors++;
                $display("FAIL len0_word: got %h required 0025", strb_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n, ns;
        wr_data = 8'h33;
        wr_valid = 1'b1;
        issue(2'd3, 5'd0, 13'd10);
        n = 0;
        ns = 0;
        while (ns < 3 && n < 200) begin
            @(negedge clk_sys);
            if (io_strobe) ns++;
            n++;
        end
        checks++;
        if (ns != 3) begin
            errors++;
            $display("FAIL rstmid_reach: saw %0d strobes required 3", ns);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({io_osd, io_strobe, busy, wr_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_drop: osd/strobe/busy/wr_ready=%b required 0000",
                     {io_osd, io_strobe, busy, wr_ready});
        end
        wr_valid = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        strb_q.delete();
        strb_t.delete();
        issue(2'd0, 5'd0, 13'd0);
        wait_done(100);
        checks++;
        if (strb_q.size() != 1 || t_done != t_acc + 5) begin
            errors++;
            $display("FAIL rstmid_op0: strobes %0d done +%0d required 1/+5",
                     strb_q.size(), t_done - t_acc);
        end else begin
            checks++;
            if (strb_q[0] !== 16'h0040 || strb_t[0] != t_acc + 2) begin
                errors++;
                $display("FAIL rstmid_word: got %h at +%0d required 0040 at +2",
                         strb_q[0], strb_t[0] - t_acc);
            end
        end
    endtask

`ifdef OSD_SEQ_AUTOHIDE_EN
    task automatic test_autohide;
        int d;
        issue(2'd1, 5'd0, 13'd0);
        wait_done(100);
        d = t_done;
        strb_q.delete();
        strb_t.delete();
        while (cyc < d + 102) @(negedge clk_sys);
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hide_ready: cmd_ready=%b busy=%b required 0/0", cmd_ready, busy);
        end
        issue(2'd1, 5'd0, 13'd0);
        wait_done(100);
        checks++;
        if (strb_q.size() != 2 || t_acc != d + 109) begin
            errors++;
            $display("FAIL hide_order: strobes %0d accept +%0d required 2/+109",
                     strb_q.size(), t_acc - d);
        end else begin
            checks++;
            if (strb_q[0] !== 16'h0040 || strb_t[0] != d + 104 ||
                strb_q[1] !== 16'h0041 || strb_t[1] != d + 111) begin
                errors++;
                $display("FAIL hide_words: got %h@+%0d %h@+%0d required 0040@+104 0041@+111",
                         strb_q[0], strb_t[0] - d, strb_q[1], strb_t[1] - d);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_op1();
        test_info();
        test_write();
        test_len0();
        test_reset_mid();
`ifdef OSD_SEQ_AUTOHIDE_EN
        test_autohide();
`endif
        repeat (3) @(negedge clk_sys);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/osd_cmd_sequencer.md
Name: osd_cmd_sequencer

Overview:
Host-side controller that drives the OSD overlay's serial command port (io_osd / io_strobe / io_din) from a simple command/data handshake. It is in the clk_sys domain between the core's menu logic and the OSD overlay. It frames each transaction, generates strobe pulses that meet the overlay's rising-edge timing, and serialises enable/disable, info-box parameters and buffer writes. With the optional feature, it also hides the OSD automatically after a period with no commands.

Parameters:
STROBE_GAP, 2, low cycles of io_strobe after each high cycle; legal range 1..15.
END_GAP, 2, cycles io_osd is held low after a transaction before the next one can be accepted; legal range 2..15.
HIDE_TIMEOUT, 24'd10_000_000, idle clk_sys cycles before auto-hide. Used only with OSD_SEQ_AUTOHIDE_EN.

Ports:
clk_sys  in  1  system clock; all logic is in this domain.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_op  in  2  0 = disable, 1 = enable, 2 = enable with info box, 3 = buffer write.
cmd_line  in  5  start line for a write; the overlay's buffer address becomes cmd_line<<8.
cmd_len  in  13  number of data bytes for a write, 0..4096.
info_x  in  12  info box X position.
info_y  in  12  info box Y position.
info_w  in  6  info box width in units of 8 pixels.
info_h  in  6  info box height in units of 8 pixels.
info_rot  in  2  rotation code.
wr_data  in  8  write data byte.
wr_valid  in  1  write data valid.
wr_ready  out  1  write byte consumed when wr_valid & wr_ready.
io_osd  out  1  transaction frame to the overlay.
io_strobe  out  1  word strobe to the overlay.
io_din  out  16  command or data word to the overlay.
busy  out  1  high whenever the sequencer is not in IDLE.
done  out  1  one-cycle pulse at the end of each transaction.

Behaviour:
- Reset (async assert): all outputs 0, state IDLE, all counters 0. cmd_ready rises the first cycle after reset deasserts.
- cmd_ready = (state == IDLE). All cmd_* and info_* inputs are latched on acceptance; later changes to them are ignored.
- Word lists per op:
  - op 0: one word, 0x0040.
  - op 1: one word, 0x0041.
  - op 2: six words: 0x0045, {4'h0, info_x}, {4'h0, info_y}, {10'h0, info_w}, {10'h0, info_h}, {14'h0, info_rot}.
  - op 3: 0x0020 | cmd_line, followed by cmd_len data words {8'h00, byte}.
  - cmd_line[3] = 1 selects highres in the overlay. The sequencer does not check this.
- States: IDLE, SETUP, STRB_HI, STRB_LO, DATA_WAIT, TAIL.
- IDLE: on accept (cycle T0), go to SETUP.
- SETUP (T1): io_osd = 1, io_strobe = 0.
- STRB_HI: io_strobe = 1 for exactly one cycle. io_din holds the current word; it is set on entry and held until the next word is loaded. The first STRB_HI is at T2.
- STRB_LO: io_strobe = 0 for STROBE_GAP cycles. Then go to:
  - STRB_HI if words remain in a non-write op;
  - DATA_WAIT if data bytes remain in a write;
  - TAIL otherwise.
- DATA_WAIT: wr_ready = 1. On a handshake, io_din <= {8'h00, wr_data} and go to STRB_HI on the next cycle. wr_ready is 0 in every other state. Stalls of any length are allowed; io_osd stays high throughout.
- TAIL: io_osd = 0 for END_GAP cycles. done pulses in the first TAIL cycle. Then go to IDLE. Enable/disable take effect in the overlay during TAIL.
- Byte counter: 13-bit, decremented on each data handshake. cmd_len = 0 sends only the command word. The sequencer does not check for overflow past the overlay buffer (the overlay's address wraps at 13 bits).
- io_osd falls only in TAIL or on reset. Reset mid-transaction drops io_osd and io_strobe the same cycle; the overlay discards the partial frame.
- Total strobes per transaction: op 0/1 = 1, op 2 = 6, op 3 = 1 + cmd_len.
- Minimum accept-to-accept spacing: 2 + words × (1 + STROBE_GAP) + END_GAP cycles, plus any data stall cycles.

Optional Feature:
OSD_SEQ_AUTOHIDE_EN
- Defined:
  - A 24-bit idle counter runs while the last completed enable (op 1/2) has not been followed by a disable.
  - The counter clears on any command accept. It saturates at HIDE_TIMEOUT.
  - On reaching HIDE_TIMEOUT in IDLE, the sequencer internally issues op 0. During this, cmd_ready = 0 and done pulses as for a normal op 0; the counter is then disarmed.
  - An external cmd_valid in the same cycle loses to auto-hide and is accepted after auto-hide completes.
- Undefined: no counter; the OSD stays in its last commanded state indefinitely.

Test Plan:
- op 1 after reset, STROBE_GAP = 2, END_GAP = 2 -> io_osd high T1..T4, single strobe at T2 with io_din = 0x0041, done at T5, cmd_ready again at T7.
- op 2 with x = 0x123, y = 0x045, w = 6, h = 3, rot = 1 -> six strobes carrying 0x0045, 0x0123, 0x0045, 0x0006, 0x0003, 0x0001; strobes 3 cycles apart.
- op 3 with line = 9, len = 3, bytes A5/5A/FF, 4-cycle wr_valid stall before the second byte -> words 0x0029, 0x00A5, 0x005A, 0x00FF; io_osd stays high through the stall; wr_ready is high only in DATA_WAIT.
- op 3 with len = 0 -> exactly one strobe (0x0020 | line), then done.
- Reset asserted during the second data word of a len = 10 write -> io_osd, io_strobe, busy = 0 immediately; the next op 0 runs normally.
- OSD_SEQ_AUTOHIDE_EN with HIDE_TIMEOUT = 100: op 1, then no commands -> 0x0040 strobe about 100 cycles after done; a competing cmd_valid in the same cycle is accepted after auto-hide's done.
